// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data-memory handshake with lane steering and load extension.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses complete immediately with bus_err_o.
module mem_stage #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              MemRE,
   input  logic              MemWE,
   input  logic [2:0]        funct3,
   input  logic [31:0]       ALUOut,
   input  logic [31:0]       DataOutReg2,
   output logic              stall_o,
   output logic              done_o,
   output logic [31:0]       ReadData,
   output logic              bus_err_o,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        off_q;
   logic [2:0]        funct3_q;
   logic              we_q;
   logic              err_q;
   logic              accept;
   logic              misalign;
   logic              timeout_hit;
   logic [3:0]        be_new;
   logic [31:0]       wdata_new;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       load_ext;

   assign accept = (state == IDLE) && valid_i && (MemRE || MemWE);

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = ((funct3[1:0] == 2'b01) && ALUOut[0]) ||
                     (funct3[1] && (ALUOut[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Lane steering uses only funct3[1:0]; word accesses ignore the low address bits.
   always_comb begin
      be_new    = 4'b1111;
      wdata_new = DataOutReg2;
      case (funct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << ALUOut[1:0];
            wdata_new = {4{DataOutReg2[7:0]}};
         end
         2'b01: begin
            be_new    = ALUOut[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{DataOutReg2[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_sel = dmem_rdata[7:0];
      case (off_q)
         2'd1:    byte_sel = dmem_rdata[15:8];
         2'd2:    byte_sel = dmem_rdata[23:16];
         2'd3:    byte_sel = dmem_rdata[31:24];
         default: ;
      endcase
      half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (funct3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'h0, byte_sel};
         3'b101:  load_ext = {16'h0, half_sel};
         default: load_ext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // An ack in the final REQ cycle wins over the timeout.
   always_comb begin
      state_next  = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE: if (accept) state_next = misalign ? RESP : REQ;
         REQ: begin
            if (dmem_ack) begin
               state_next = RESP;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_next  = RESP;
               timeout_hit = 1'b1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         off_q      <= '0;
         funct3_q   <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         ReadData   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (accept) begin
                  dmem_addr  <= {ALUOut[ADDR_W-1:2], 2'b00};
                  off_q      <= ALUOut[1:0];
                  funct3_q   <= funct3;
                  we_q       <= MemWE;
                  dmem_be    <= be_new;
                  dmem_wdata <= wdata_new;
                  err_q      <= misalign;
                  if (misalign) ReadData <= '0;
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  err_q <= 1'b0;
                  if (!we_q) ReadData <= load_ext;
               end else if (timeout_hit) begin
                  err_q    <= 1'b1;
                  ReadData <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign stall_o   = accept || (state == REQ);
   assign done_o    = (state == RESP);
   assign bus_err_o = (state == RESP) && err_q;
   assign dmem_req  = (state == REQ);
   assign dmem_we   = (state == REQ) && we_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        MemRE;
   logic        MemWE;
   logic [2:0]  funct3;
   logic [31:0] ALUOut;
   logic [31:0] DataOutReg2;
   logic        stall_o;
   logic        done_o;
   logic [31:0] ReadData;
   logic        bus_err_o;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   int checks = 0;
   int errors = 0;
   int req_cycles;
   int done_seen;

   mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .MemRE(MemRE), .MemWE(MemWE),
      .funct3(funct3), .ALUOut(ALUOut), .DataOutReg2(DataOutReg2),
      .stall_o(stall_o), .done_o(done_o), .ReadData(ReadData), .bus_err_o(bus_err_o),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one op at a negedge, checks the accept-cycle stall, and returns at the next negedge.
   task automatic applyStimulus(input logic re, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] data);
      valid_i     = 1'b1;
      MemRE       = re;
      MemWE       = we;
      funct3      = f3;
      ALUOut      = addr;
      DataOutReg2 = data;
      #1;
      checkOutput("accept_stall", 32'(stall_o), 32'd1);
      @(negedge clk);
      valid_i = 1'b0;
      MemRE   = 1'b0;
      MemWE   = 1'b0;
   endtask

   task automatic ackOnce(input logic [31:0] rdata);
      dmem_rdata = rdata;
      dmem_ack   = 1'b1;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
   endtask

   initial begin
      rst = 1'b1;
      valid_i = 1'b0; MemRE = 1'b0; MemWE = 1'b0; funct3 = 3'b000;
      ALUOut = 32'h0; DataOutReg2 = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_stall", 32'(stall_o), 32'd0);
      checkOutput("rst_done", 32'(done_o), 32'd0);
      checkOutput("rst_req", 32'(dmem_req), 32'd0);
      checkOutput("rst_rdata", ReadData, 32'h0);
      checkOutput("rst_be", 32'(dmem_be), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] SW word store");
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
      checkOutput("sw_req", 32'(dmem_req), 32'd1);
      checkOutput("sw_we", 32'(dmem_we), 32'd1);
      checkOutput("sw_addr", dmem_addr, 32'h0000_0104);
      checkOutput("sw_be", 32'(dmem_be), 32'hF);
      checkOutput("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
      checkOutput("sw_stall_req", 32'(stall_o), 32'd1);
      checkOutput("sw_done_early", 32'(done_o), 32'd0);
      ackOnce(32'h1234_5678);
      checkOutput("sw_done", 32'(done_o), 32'd1);
      checkOutput("sw_stall_resp", 32'(stall_o), 32'd0);
      checkOutput("sw_err", 32'(bus_err_o), 32'd0);
      checkOutput("sw_req_resp", 32'(dmem_req), 32'd0);
      checkOutput("sw_rdata_kept", ReadData, 32'h0);
      @(negedge clk);
      checkOutput("sw_done_pulse", 32'(done_o), 32'd0);

      $display("[TB] SB byte store");
      applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
      checkOutput("sb_addr", dmem_addr, 32'h0000_0100);
      checkOutput("sb_be", 32'(dmem_be), 32'h8);
      checkOutput("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
      ackOnce(32'h0);
      checkOutput("sb_done", 32'(done_o), 32'd1);
      @(negedge clk);

      $display("[TB] load timeout");
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
      req_cycles = 0;
      done_seen  = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_o) begin
            done_seen = 1;
            break;
         end
         if (dmem_req) req_cycles++;
         @(negedge clk);
      end
      checkOutput("to_done_seen", 32'(done_seen), 32'd1);
      checkOutput("to_req_cycles", 32'(req_cycles), 32'd16);
      checkOutput("to_err", 32'(bus_err_o), 32'd1);
      checkOutput("to_rdata", ReadData, 32'h0);
      checkOutput("to_stall", 32'(stall_o), 32'd0);
      @(negedge clk);

      $display("[TB] sub-word loads");
      applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0202, 32'h0);
      checkOutput("lb_addr", dmem_addr, 32'h0000_0200);
      checkOutput("lb_we", 32'(dmem_we), 32'd0);
      checkOutput("lb_be", 32'(dmem_be), 32'h4);
      ackOnce(32'h0080_0000);
      checkOutput("lb_done", 32'(done_o), 32'd1);
      checkOutput("lb_rdata", ReadData, 32'hFFFF_FF80);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0202, 32'h0);
      ackOnce(32'h0080_0000);
      checkOutput("lbu_rdata", ReadData, 32'h0000_0080);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0);
      checkOutput("lhu_be", 32'(dmem_be), 32'hC);
      ackOnce(32'h8001_0000);
      checkOutput("lhu_rdata", ReadData, 32'h0000_8001);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0);
      checkOutput("lh_be", 32'(dmem_be), 32'h3);
      ackOnce(32'h1234_9ABC);
      checkOutput("lh_rdata", ReadData, 32'hFFFF_9ABC);
      @(negedge clk);

      $display("[TB] misaligned LW");
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      checkOutput("mis_req", 32'(dmem_req), 32'd0);
      checkOutput("mis_done", 32'(done_o), 32'd1);
      checkOutput("mis_err", 32'(bus_err_o), 32'd1);
      checkOutput("mis_rdata", ReadData, 32'h0);
      @(negedge clk);
      checkOutput("mis_req_after", 32'(dmem_req), 32'd0);
`else
      checkOutput("mis_req", 32'(dmem_req), 32'd1);
      checkOutput("mis_addr", dmem_addr, 32'h0000_0004);
      checkOutput("mis_be", 32'(dmem_be), 32'hF);
      ackOnce(32'h1122_3344);
      checkOutput("mis_done", 32'(done_o), 32'd1);
      checkOutput("mis_err", 32'(bus_err_o), 32'd0);
      checkOutput("mis_rdata", ReadData, 32'h1122_3344);
      @(negedge clk);
`endif

      $display("[TB] SH half store keeps ReadData");
      applyStimulus(1'b1, 1'b1, 3'b001, 32'h0000_0202, 32'hFFFF_1234);
      checkOutput("sh_we", 32'(dmem_we), 32'd1);
      checkOutput("sh_be", 32'(dmem_be), 32'hC);
      checkOutput("sh_wdata", dmem_wdata, 32'h1234_1234);
      ackOnce(32'hCAFE_F00D);
`ifdef MEM_MISALIGN_TRAP_EN
      checkOutput("sh_rdata_kept", ReadData, 32'h0);
`else
      checkOutput("sh_rdata_kept", ReadData, 32'h1122_3344);
`endif
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
      ackOnce(32'h5555_AAAA);
      checkOutput("lw_rdata", ReadData, 32'h5555_AAAA);
      @(negedge clk);

      $display("[TB] reset during REQ");
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h7777_7777);
      checkOutput("rr_req_before", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("rr_req", 32'(dmem_req), 32'd0);
      checkOutput("rr_stall", 32'(stall_o), 32'd0);
      checkOutput("rr_we", 32'(dmem_we), 32'd0);
      checkOutput("rr_addr", dmem_addr, 32'h0);
      checkOutput("rr_wdata", dmem_wdata, 32'h0);
      checkOutput("rr_rdata", ReadData, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      dmem_ack = 1'b1;
      #1;
      checkOutput("rr_ack_stall", 32'(stall_o), 32'd0);
      @(negedge clk);
      dmem_ack = 1'b0;
      checkOutput("rr_ack_done", 32'(done_o), 32'd0);
      @(negedge clk);
      checkOutput("rr_ack_done2", 32'(done_o), 32'd0);
      checkOutput("rr_ack_req", 32'(dmem_req), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
